// File: rtl/ppu_pkg.sv
// Shared constants and the palette mirror function for the PPU pixel path.
package ppu_pkg;

  localparam int IDX_W_D  = 4;
  localparam int PAL_DW_D = 6;
  localparam int CLIP_W_D = 8;
  localparam int PAL_AW   = IDX_W_D + 1;

  localparam logic [PAL_DW_D-1:0] PAL_RESET_VAL = 6'h0F;
  localparam logic [PAL_DW_D-1:0] GREY_MASK     = 6'h30;

  // Entries 0x10/0x14/0x18/0x1C alias the shared backdrop slots 0x00/0x04/0x08/0x0C.
  function automatic logic [PAL_AW-1:0] pal_mirror(input logic [PAL_AW-1:0] a);
    logic [PAL_AW-1:0] m;
    m = a;
    if (a[1:0] == 2'b00) m[PAL_AW-1] = 1'b0;
    return m;
  endfunction

endpackage

// File: rtl/ppu_pram.sv
// Palette RAM: registered register-interface port plus combinational pixel read port.
module ppu_pram
  import ppu_pkg::*;
#(
  parameter int AW = PAL_AW,
  parameter int DW = PAL_DW_D
) (
  input  logic          clk_in,
  input  logic          nrst_in,
  input  logic [AW-1:0] reg_a_in,
  input  logic [DW-1:0] reg_d_in,
  input  logic          reg_wr_in,
  output logic [DW-1:0] reg_q_out,
  input  logic [AW-1:0] pix_a_in,
  output logic [DW-1:0] pix_q_out
);

  localparam int DEPTH = 2 ** AW;

  logic [DW-1:0] mem [DEPTH];

  // Pixel read sees the pre-edge contents, so a same-cycle write is not visible.
  assign pix_q_out = mem[pal_mirror(pix_a_in)];

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= PAL_RESET_VAL;
      reg_q_out <= '0;
    end else begin
      if (reg_wr_in) mem[pal_mirror(reg_a_in)] <= reg_d_in;
      reg_q_out <= mem[pal_mirror(reg_a_in)];
    end
  end

endmodule

// File: rtl/ppu_pix_mux.sv
// Two-stage pixel compositor: layer priority/clipping, then palette lookup with greyscale.
module ppu_pix_mux
  import ppu_pkg::*;
#(
  parameter int IDX_W  = IDX_W_D,
  parameter int PAL_DW = PAL_DW_D,
  parameter int X_W    = 10,
  parameter int CLIP_W = CLIP_W_D
) (
  input  logic              clk_in,
  input  logic              nrst_in,
  input  logic              pix_valid_in,
  input  logic [X_W-1:0]    nes_x_in,
  input  logic              frame_start_in,
  input  logic [IDX_W-1:0]  bg_idx_in,
  input  logic [IDX_W-1:0]  spr_idx_in,
  input  logic              spr_primary_in,
  input  logic              spr_priority_in,
  input  logic              bg_clip_in,
  input  logic              spr_clip_in,
  input  logic              grey_in,
  input  logic [2:0]        emph_in,
  input  logic [IDX_W:0]    pram_a_in,
  input  logic [PAL_DW-1:0] pram_d_in,
  input  logic              pram_wr_in,
  output logic [PAL_DW-1:0] pram_d_out,
  output logic              pix_valid_out,
  output logic [PAL_DW-1:0] sys_idx_out,
  output logic [2:0]        emph_out,
  output logic              pri_col_out
);

  // Valid contract: pix_valid_in is a one-cycle qualifier with no backpressure;
  // each accepted pixel emerges exactly two cycles later with pix_valid_out high.

  logic             clipped;
  logic             bg_t;
  logic             spr_t;
  logic [IDX_W:0]   sel_addr;
  logic             hit;

  logic             s1_valid;
  logic [IDX_W:0]   s1_addr;
  logic             s1_grey;
  logic [2:0]       s1_emph;
  logic [PAL_DW-1:0] pix_q;

  always_comb begin
    clipped  = (nes_x_in < X_W'(CLIP_W));
    bg_t     = (bg_idx_in[1:0] == 2'b00) || (bg_clip_in && clipped);
    spr_t    = (spr_idx_in[1:0] == 2'b00) || (spr_clip_in && clipped);
    sel_addr = '0;
    if (!spr_t && (!spr_priority_in || bg_t)) sel_addr = {1'b1, spr_idx_in};
    else if (!bg_t)                           sel_addr = {1'b0, bg_idx_in};
    hit      = pix_valid_in && spr_primary_in && !spr_t && !bg_t;
  end

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      s1_valid <= 1'b0;
      s1_addr  <= '0;
      s1_grey  <= 1'b0;
      s1_emph  <= '0;
    end else begin
      s1_valid <= pix_valid_in;
      if (pix_valid_in) begin
        s1_addr <= sel_addr;
        s1_grey <= grey_in;
        s1_emph <= emph_in;
      end
    end
  end

  ppu_pram #(.AW(IDX_W + 1), .DW(PAL_DW)) u_pram (
    .clk_in    (clk_in),
    .nrst_in   (nrst_in),
    .reg_a_in  (pram_a_in),
    .reg_d_in  (pram_d_in),
    .reg_wr_in (pram_wr_in),
    .reg_q_out (pram_d_out),
    .pix_a_in  (s1_addr),
    .pix_q_out (pix_q)
  );

  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in) begin
      pix_valid_out <= 1'b0;
      sys_idx_out   <= '0;
      emph_out      <= '0;
    end else begin
      pix_valid_out <= s1_valid;
      if (s1_valid) begin
        sys_idx_out <= s1_grey ? (pix_q & GREY_MASK) : pix_q;
        emph_out    <= s1_emph;
      end
    end
  end

  // Frame start takes precedence over a coincident hit.
  always_ff @(posedge clk_in or negedge nrst_in) begin
    if (!nrst_in)            pri_col_out <= 1'b0;
    else if (frame_start_in) pri_col_out <= 1'b0;
    else if (hit)            pri_col_out <= 1'b1;
  end

endmodule

// File: tb/tb_ppu_pix_mux.sv
// Self-checking bench for ppu_pix_mux: scoreboard of expected {emph, sys_idx} per pixel.
module tb_ppu_pix_mux;

  logic       clk_in = 1'b0;
  logic       nrst_in = 1'b0;
  logic       pix_valid_in = 1'b0;
  logic [9:0] nes_x_in = '0;
  logic       frame_start_in = 1'b0;
  logic [3:0] bg_idx_in = '0;
  logic [3:0] spr_idx_in = '0;
  logic       spr_primary_in = 1'b0;
  logic       spr_priority_in = 1'b0;
  logic       bg_clip_in = 1'b0;
  logic       spr_clip_in = 1'b0;
  logic       grey_in = 1'b0;
  logic [2:0] emph_in = '0;
  logic [4:0] pram_a_in = '0;
  logic [5:0] pram_d_in = '0;
  logic       pram_wr_in = 1'b0;
  logic [5:0] pram_d_out;
  logic       pix_valid_out;
  logic [5:0] sys_idx_out;
  logic [2:0] emph_out;
  logic       pri_col_out;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  logic [8:0] exp_q[$];
  int         lat_q[$];
  logic [5:0] pal_model [32];

  ppu_pix_mux dut (
    .clk_in          (clk_in),
    .nrst_in         (nrst_in),
    .pix_valid_in    (pix_valid_in),
    .nes_x_in        (nes_x_in),
    .frame_start_in  (frame_start_in),
    .bg_idx_in       (bg_idx_in),
    .spr_idx_in      (spr_idx_in),
    .spr_primary_in  (spr_primary_in),
    .spr_priority_in (spr_priority_in),
    .bg_clip_in      (bg_clip_in),
    .spr_clip_in     (spr_clip_in),
    .grey_in         (grey_in),
    .emph_in         (emph_in),
    .pram_a_in       (pram_a_in),
    .pram_d_in       (pram_d_in),
    .pram_wr_in      (pram_wr_in),
    .pram_d_out      (pram_d_out),
    .pix_valid_out   (pix_valid_out),
    .sys_idx_out     (sys_idx_out),
    .emph_out        (emph_out),
    .pri_col_out     (pri_col_out)
  );

  // clock / reset
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [4:0] mir(input logic [4:0] a);
    return (a[1:0] == 2'b00) ? (a & 5'h0F) : a;
  endfunction

  // scoreboard monitor
  always @(negedge clk_in) begin
    if (nrst_in && pix_valid_out) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pixel: got sys=%h emph=%b, expected no output", sys_idx_out, emph_out);
      end else begin
        logic [8:0] e;
        int c0;
        e  = exp_q.pop_front();
        c0 = lat_q.pop_front();
        if ({emph_out, sys_idx_out} !== e) begin
          mismatched++;
          $display("FAIL pixel_out: got emph=%b sys=%h, expected emph=%b sys=%h", emph_out, sys_idx_out, e[8:6], e[5:0]);
        end
        compared++;
        if (cyc - c0 != 2) begin
          mismatched++;
          $display("FAIL latency: got %0d cycles, expected 2", cyc - c0);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_in);
    #1;
    pix_valid_in = 1'b0;
    pram_wr_in = 1'b0;
    frame_start_in = 1'b0;
    spr_primary_in = 1'b0;
  endtask

  task automatic pram_write(input logic [4:0] a, input logic [5:0] d);
    pram_a_in = a;
    pram_d_in = d;
    pram_wr_in = 1'b1;
    pal_model[mir(a)] = d;
    tick();
  endtask

  task automatic set_pix(input logic [3:0] bg, input logic [3:0] spr, input logic pri,
                         input logic [9:0] x, input logic bclip, input logic sclip,
                         input logic grey, input logic [2:0] emph, input logic [5:0] exp_sys);
    pix_valid_in = 1'b1;
    bg_idx_in = bg;
    spr_idx_in = spr;
    spr_priority_in = pri;
    nes_x_in = x;
    bg_clip_in = bclip;
    spr_clip_in = sclip;
    grey_in = grey;
    emph_in = emph;
    exp_q.push_back({emph, exp_sys});
    lat_q.push_back(cyc);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending pixels, expected 0", exp_q.size());
      exp_q.delete();
      lat_q.delete();
    end
  endtask

  task automatic check_pram(input logic [4:0] a, input logic [5:0] e, input string nm);
    pram_a_in = a;
    tick();
    compared++;
    if (pram_d_out !== e) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h", nm, pram_d_out, e);
    end
  endtask

  task automatic check_hit(input logic e, input string nm);
    compared++;
    if (pri_col_out !== e) begin
      mismatched++;
      $display("FAIL %s: got %b, expected %b", nm, pri_col_out, e);
    end
  endtask

  task automatic do_reset();
    nrst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    nrst_in = 1'b1;
    for (int i = 0; i < 32; i++) pal_model[i] = 6'h0F;
  endtask

  // scenario tasks
  task automatic test_reset();
    do_reset();
    compared += 4;
    if (pix_valid_out !== 1'b0) begin mismatched++; $display("FAIL rst_valid: got %b, expected 0", pix_valid_out); end
    if (sys_idx_out !== 6'h00)  begin mismatched++; $display("FAIL rst_sys: got %h, expected 00", sys_idx_out); end
    if (emph_out !== 3'b000)    begin mismatched++; $display("FAIL rst_emph: got %b, expected 000", emph_out); end
    if (pram_d_out !== 6'h00)   begin mismatched++; $display("FAIL rst_pram_d: got %h, expected 00", pram_d_out); end
    check_hit(1'b0, "rst_hit");
    check_pram(5'h03, 6'h0F, "rst_pal_03");
    check_pram(5'h1D, 6'h0F, "rst_pal_1d");
  endtask

  task automatic test_opaque();
    pram_write(5'h15, 6'h11);
    pram_write(5'h06, 6'h22);
    set_pix(4'h6, 4'h5, 1'b0, 10'd100, 1'b0, 1'b0, 1'b0, 3'b000, 6'h11);
    tick();
    set_pix(4'h6, 4'h5, 1'b1, 10'd101, 1'b0, 1'b0, 1'b0, 3'b000, 6'h22);
    tick();
    drain();
  endtask

  task automatic test_transparent();
    pram_write(5'h10, 6'h2D);
    set_pix(4'h4, 4'h8, 1'b0, 10'd50, 1'b0, 1'b0, 1'b0, 3'b000, 6'h2D);
    tick();
    drain();
    check_pram(5'h00, 6'h2D, "mirror_read_00");
    check_pram(5'h10, 6'h2D, "mirror_read_10");
    check_pram(5'h15, 6'h11, "read_15");
  endtask

  task automatic test_clip();
    set_pix(4'h6, 4'h0, 1'b0, 10'd7, 1'b1, 1'b0, 1'b0, 3'b000, 6'h2D);
    tick();
    set_pix(4'h6, 4'h0, 1'b0, 10'd8, 1'b1, 1'b0, 1'b0, 3'b000, 6'h22);
    tick();
    set_pix(4'h6, 4'h5, 1'b0, 10'd0, 1'b0, 1'b1, 1'b0, 3'b000, 6'h22);
    tick();
    set_pix(4'h6, 4'h5, 1'b0, 10'd8, 1'b0, 1'b1, 1'b0, 3'b000, 6'h11);
    tick();
    drain();
  endtask

  task automatic test_grey();
    pram_write(5'h07, 6'h27);
    set_pix(4'h7, 4'h0, 1'b0, 10'd30, 1'b0, 1'b0, 1'b1, 3'b101, 6'h20);
    tick();
    set_pix(4'h7, 4'h0, 1'b0, 10'd31, 1'b0, 1'b0, 1'b0, 3'b010, 6'h27);
    tick();
    drain();
  endtask

  task automatic test_sprite0_hit();
    frame_start_in = 1'b1;
    tick();
    check_hit(1'b0, "hit_cleared");
    // primary sprite over transparent background: no hit
    set_pix(4'h4, 4'h5, 1'b0, 10'd40, 1'b0, 1'b0, 1'b0, 3'b000, 6'h11);
    spr_primary_in = 1'b1;
    tick();
    check_hit(1'b0, "hit_bg_transparent");
    // behind-background priority still registers a hit
    set_pix(4'h6, 4'h5, 1'b1, 10'd41, 1'b0, 1'b0, 1'b0, 3'b000, 6'h22);
    spr_primary_in = 1'b1;
    tick();
    check_hit(1'b1, "hit_set");
    repeat (3) tick();
    check_hit(1'b1, "hit_sticky");
    set_pix(4'h6, 4'h5, 1'b0, 10'd42, 1'b0, 1'b0, 1'b0, 3'b000, 6'h11);
    spr_primary_in = 1'b1;
    frame_start_in = 1'b1;
    tick();
    check_hit(1'b0, "hit_clear_wins");
    drain();
  endtask

  task automatic test_collision();
    set_pix(4'h6, 4'h0, 1'b0, 10'd60, 1'b0, 1'b0, 1'b0, 3'b000, 6'h22);
    tick();
    set_pix(4'h6, 4'h0, 1'b0, 10'd61, 1'b0, 1'b0, 1'b0, 3'b000, 6'h30);
    pram_a_in = 5'h06;
    pram_d_in = 6'h30;
    pram_wr_in = 1'b1;
    pal_model[5'h06] = 6'h30;
    tick();
    drain();
    check_pram(5'h06, 6'h30, "collision_reg_read");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 32; i++)
      pram_write(5'(i), 6'($urandom_range(0, 63)));
    for (int i = 0; i < 24; i++) begin
      logic [3:0] bg, spr;
      logic pri, bc, sc, gr, bt, st;
      logic [9:0] x;
      logic [2:0] em;
      logic [4:0] a;
      logic [5:0] v;
      bg = 4'($urandom_range(0, 15));
      spr = 4'($urandom_range(0, 15));
      pri = 1'($urandom_range(0, 1));
      bc = 1'($urandom_range(0, 1));
      sc = 1'($urandom_range(0, 1));
      gr = 1'($urandom_range(0, 1));
      em = 3'($urandom_range(0, 7));
      x = 10'($urandom_range(0, 15));
      bt = (bg[1:0] == 2'b00) || (bc && x < 10'd8);
      st = (spr[1:0] == 2'b00) || (sc && x < 10'd8);
      if (st) a = bt ? 5'h00 : {1'b0, bg};
      else if (pri && !bt) a = {1'b0, bg};
      else a = {1'b1, spr};
      v = pal_model[mir(a)];
      if (gr) v = v & 6'h30;
      set_pix(bg, spr, pri, x, bc, sc, gr, em, v);
      tick();
    end
    drain();
  endtask

  task automatic test_reset_mid();
    pram_write(5'h06, 6'h3A);
    set_pix(4'h6, 4'h5, 1'b0, 10'd70, 1'b0, 1'b0, 1'b0, 3'b000, 6'h00);
    spr_primary_in = 1'b1;
    tick();
    #2;
    nrst_in = 1'b0;
    exp_q.delete();
    lat_q.delete();
    #1;
    compared++;
    if (pix_valid_out !== 1'b0) begin mismatched++; $display("FAIL midrst_valid: got %b, expected 0", pix_valid_out); end
    check_hit(1'b0, "midrst_hit");
    repeat (3) @(negedge clk_in);
    compared++;
    if (pix_valid_out !== 1'b0) begin mismatched++; $display("FAIL midrst_no_output: got %b, expected 0", pix_valid_out); end
    @(posedge clk_in);
    #1;
    nrst_in = 1'b1;
    for (int i = 0; i < 32; i++) pal_model[i] = 6'h0F;
    check_pram(5'h06, 6'h0F, "midrst_pal_06");
    set_pix(4'h6, 4'h0, 1'b0, 10'd80, 1'b0, 1'b0, 1'b0, 3'b000, 6'h0F);
    tick();
    drain();
  endtask

  initial begin
    test_reset();
    test_opaque();
    test_transparent();
    test_clip();
    test_grey();
    test_sprite0_hit();
    test_collision();
    test_back_to_back();
    test_reset_mid();
    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ppu_pix_mux.md
Name: ppu_pix_mux

Overview:
Pipelined pixel compositor for the PPU. It resolves background and sprite palette indices into a final system palette index, and owns the 32-entry palette RAM with its register-interface read/write port. It sits between ppu_bg/ppu_spr and ppu_vga, replacing the combinational mux in the PPU top. Compared with the previous mux, it adds per-layer left-column clipping, greyscale, colour-emphasis passthrough, a registered valid/latency contract and parametrised widths.

Parameters:
IDX_W, 4, per-layer palette index width ({attr[1:0], pattern[1:0]})
PAL_DW, 6, palette entry width (system palette index)
X_W, 10, width of the nes_x coordinate
CLIP_W, 8, number of leftmost pixels suppressed when a clip input is set

Ports:
clk_in  in  1  system clock (100MHz)
nrst_in  in  1  asynchronous active-low reset
pix_valid_in  in  1  one-cycle pulse; the layer inputs are valid for this pixel
nes_x_in  in  X_W  x coordinate of the current pixel
frame_start_in  in  1  one-cycle pulse at the start of the pre-render line
bg_idx_in  in  IDX_W  background palette index
spr_idx_in  in  IDX_W  sprite palette index
spr_primary_in  in  1  current sprite pixel comes from OAM entry 0
spr_priority_in  in  1  1 = sprite is behind the background
bg_clip_in  in  1  1 = hide background for x < CLIP_W
spr_clip_in  in  1  1 = hide sprites for x < CLIP_W
grey_in  in  1  greyscale mode enable
emph_in  in  3  colour emphasis bits (RGB)
pram_a_in  in  IDX_W+1  register-interface palette address
pram_d_in  in  PAL_DW  register-interface write data
pram_wr_in  in  1  palette write strobe
pram_d_out  out  PAL_DW  register-interface palette read data
pix_valid_out  out  1  sys_idx_out is valid
sys_idx_out  out  PAL_DW  final system palette index
emph_out  out  3  emphasis bits aligned with sys_idx_out
pri_col_out  out  1  sticky sprite-0 hit flag

Behaviour:
- Clock and reset: one clock, clk_in. nrst_in is asynchronous and active-low.
- Reset values: all outputs 0. Every palette entry resets to 0x0F. pri_col_out resets to 0.
- Mirror function M(a): if a[1:0] == 0, M(a) = a & 0x0F; otherwise M(a) = a. M is applied to every palette access, whether read or write.
- Stage 1 (capture cycle of pix_valid_in):
  - clipped = (nes_x_in < CLIP_W).
  - bg_t = (bg_idx_in[1:0] == 0) or (bg_clip_in and clipped).
  - spr_t = (spr_idx_in[1:0] == 0) or (spr_clip_in and clipped).
  - Selected address:
    - {1, spr_idx_in} if !spr_t and (!spr_priority_in or bg_t);
    - otherwise {0, bg_idx_in} if !bg_t;
    - otherwise 0.
  - The selected address, grey_in and emph_in are registered with a stage-1 valid bit.
- Stage 2: read the palette at M(addr). If grey is set, AND the entry with 0x30. Register the result into sys_idx_out and emph_out, and set pix_valid_out.
- Latency: pix_valid_out asserts exactly 2 cycles after pix_valid_in.
  - Back-to-back pix_valid_in pulses are fully supported, one pixel per cycle.
  - sys_idx_out holds its last value while pix_valid_out is low.
- Sprite-0 hit:
  - In stage 1, if pix_valid_in and spr_primary_in and !spr_t and !bg_t, pri_col_out is set on the next edge.
  - The flag is sticky and is cleared by frame_start_in.
  - If a hit and frame_start_in occur in the same cycle, the clear wins.
  - The flag is independent of sprite priority.
- Palette write: on pram_wr_in, entry M(pram_a_in) <= pram_d_in on the clock edge.
  - A stage-2 read of the same entry in the same cycle returns the old value (read-before-write).
- Palette read port: pram_d_out = entry M(pram_a_in), registered, with 1-cycle latency.
  - A read in the cycle after a write to the same entry returns the new data.
- Reset asserted mid-frame: the pipeline valid bits clear immediately. The palette and the hit flag return to their reset values.

Decomposition:
- Shared package ppu_pkg holds:
  - palette mirror function M;
  - PAL_RESET_VAL (0x0F);
  - GREY_MASK (0x30);
  - default IDX_W, PAL_DW and CLIP_W constants.
- One natural sub-module, ppu_pram. It is a dual-port (one write/read register port plus one pixel read port) palette RAM with built-in mirroring and reset init.
- Priority resolution and the hit flag stay in ppu_pix_mux.

Test Plan:
- Opaque sprite over background: write 0x11 to entry 0x15 and 0x22 to entry 0x06. Drive bg_idx=0x6, spr_idx=0x5, priority=0 -> sys_idx_out=0x11 two cycles later. With priority=1 -> 0x22.
- Both layers transparent: write 0x2D to entry 0x10 (mirrors to 0x00). Drive bg_idx=0x4, spr_idx=0x8 -> sys_idx_out=0x2D. pram_d_out with pram_a_in=0x00 reads 0x2D.
- Left clip: bg_clip=1, nes_x=7, bg_idx=0x6 (entry 0x22), spr transparent -> backdrop value. At nes_x=8 -> 0x22.
- Greyscale and emphasis: entry value 0x27, grey=1, emph=3'b101 -> sys_idx_out=0x20, emph_out=3'b101, aligned on the same cycle.
- Sprite-0 hit: opaque primary sprite over opaque background -> pri_col_out=1 and stays 1. A frame_start pulse coincident with a new hit -> pri_col_out=0.
- Write/read collision: pram_wr to 0x06 with value 0x30 in the same cycle a pixel reads 0x06 (old value 0x22) -> that pixel outputs 0x22. The next pixel outputs 0x30.
